// File: rtl/decode_exec_reg.sv
// ---------------------------------------------------------------------------
// decode_exec_reg
//
// ID/EX pipeline register with hazard control. Each cycle it either captures
// the decoded control bundle from ID or inserts a bubble. It inserts a bubble
// when EX redirects the fetch stream (taken branch or jump), or when the ID
// instruction needs the result of a load that is still in EX. It also drives
// the hold/clear controls for the IF/ID register and keeps saturating counts
// of both bubble causes.
//
// Ports
//   clk, rst              rising-edge clock, synchronous active-high reset
//   id_valid              ID instruction is real (not a bubble)
//   ctl_alu_op[1:0]       ALU-op class (00 add, 01 sub, 10 R-type)
//   ctl_reg_dst .. ctl_jump   single-bit decoded control bundle
//   id_rs1/id_rs2/id_rd   ID register specifiers
//   ex_redirect           taken branch/jump resolved in EX this cycle
//   ex_hold               downstream cannot accept a new instruction
//   ex_alu_op .. ex_jump  registered control bundle in EX
//   ex_rd, ex_valid       registered destination register and valid bit
//   stall_if_id           hold the IF/ID register this cycle
//   flush_if_id           clear the IF/ID register this cycle
//   ex_src[1:0]           source of the EX contents: 00 RUN, 01 BUB_LU, 10 BUB_FL
//   lu_cnt, fl_cnt        saturating load-use / flush bubble counters
// ---------------------------------------------------------------------------
module decode_exec_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [1:0]  ctl_alu_op,
  input  logic        ctl_reg_dst,
  input  logic        ctl_branch,
  input  logic        ctl_mem_read,
  input  logic        ctl_mem_2_reg,
  input  logic        ctl_mem_write,
  input  logic        ctl_alu_src,
  input  logic        ctl_reg_write,
  input  logic        ctl_jump,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic        ex_redirect,
  input  logic        ex_hold,
  output logic [1:0]  ex_alu_op,
  output logic        ex_reg_dst,
  output logic        ex_branch,
  output logic        ex_mem_read,
  output logic        ex_mem_2_reg,
  output logic        ex_mem_write,
  output logic        ex_alu_src,
  output logic        ex_reg_write,
  output logic        ex_jump,
  output logic [4:0]  ex_rd,
  output logic        ex_valid,
  output logic        stall_if_id,
  output logic        flush_if_id,
  output logic [1:0]  ex_src,
  output logic [15:0] lu_cnt,
  output logic [15:0] fl_cnt
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_BUB_LU = 2'b01,
    ST_BUB_FL = 2'b10
  } state_e;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       reg_dst;
    logic       branch;
    logic       mem_read;
    logic       mem_2_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic       jump;
  } ctl_t;

  localparam ctl_t      CtlBubble = '0;
  localparam logic [15:0] CntMax  = 16'hFFFF;

  ctl_t        ctl_in;
  ctl_t        ctl_q, ctl_d;
  logic [4:0]  rd_q, rd_d;
  logic        valid_q, valid_d;
  state_e      state_q, state_d;
  logic [15:0] lu_cnt_q, lu_cnt_d;
  logic [15:0] fl_cnt_q, fl_cnt_d;
  logic        load_use;
  logic        rs_match;

  // Gather the loose control inputs into one bundle so bubble insertion and
  // capture can treat them as a unit.
  always_comb begin
    ctl_in           = CtlBubble;
    ctl_in.alu_op    = ctl_alu_op;
    ctl_in.reg_dst   = ctl_reg_dst;
    ctl_in.branch    = ctl_branch;
    ctl_in.mem_read  = ctl_mem_read;
    ctl_in.mem_2_reg = ctl_mem_2_reg;
    ctl_in.mem_write = ctl_mem_write;
    ctl_in.alu_src   = ctl_alu_src;
    ctl_in.reg_write = ctl_reg_write;
    ctl_in.jump      = ctl_jump;
  end

  // A load in EX whose destination feeds the ID instruction cannot be
  // forwarded in time. Register x0 never carries a real dependency.
  always_comb begin
    rs_match = (rd_q == id_rs1) || (rd_q == id_rs2);
    load_use = id_valid && valid_q && ctl_q.mem_read && (rd_q != 5'd0) && rs_match;
  end

  // Next-state and IF/ID control. Priority: reset, hold, redirect, load-use,
  // normal. A redirect discards the ID instruction anyway, so it wins over
  // load-use and the stall stays low; this keeps stall and flush exclusive.
  always_comb begin
    ctl_d       = ctl_q;
    rd_d        = rd_q;
    valid_d     = valid_q;
    state_d     = state_q;
    lu_cnt_d    = lu_cnt_q;
    fl_cnt_d    = fl_cnt_q;
    stall_if_id = 1'b0;
    flush_if_id = 1'b0;

    if (rst) begin
      // Register contents are cleared in the sequential block; IF/ID
      // controls stay low so nothing held or flushed survives reset.
      stall_if_id = 1'b0;
      flush_if_id = 1'b0;
    end else if (ex_hold) begin
      stall_if_id = 1'b1;
    end else if (ex_redirect) begin
      flush_if_id = 1'b1;
      ctl_d       = CtlBubble;
      rd_d        = 5'd0;
      valid_d     = 1'b0;
      state_d     = ST_BUB_FL;
      fl_cnt_d    = (fl_cnt_q == CntMax) ? fl_cnt_q : fl_cnt_q + 16'd1;
    end else if (load_use) begin
      stall_if_id = 1'b1;
      ctl_d       = CtlBubble;
      rd_d        = 5'd0;
      valid_d     = 1'b0;
      state_d     = ST_BUB_LU;
      lu_cnt_d    = (lu_cnt_q == CntMax) ? lu_cnt_q : lu_cnt_q + 16'd1;
    end else begin
      // An invalid ID slot enters EX as a clean bubble whatever the decoder
      // happens to be producing.
      ctl_d   = id_valid ? ctl_in : CtlBubble;
      rd_d    = id_valid ? id_rd : 5'd0;
      valid_d = id_valid;
      state_d = ST_RUN;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctl_q    <= CtlBubble;
      rd_q     <= 5'd0;
      valid_q  <= 1'b0;
      state_q  <= ST_RUN;
      lu_cnt_q <= 16'd0;
      fl_cnt_q <= 16'd0;
    end else begin
      ctl_q    <= ctl_d;
      rd_q     <= rd_d;
      valid_q  <= valid_d;
      state_q  <= state_d;
      lu_cnt_q <= lu_cnt_d;
      fl_cnt_q <= fl_cnt_d;
    end
  end

  assign ex_alu_op    = ctl_q.alu_op;
  assign ex_reg_dst   = ctl_q.reg_dst;
  assign ex_branch    = ctl_q.branch;
  assign ex_mem_read  = ctl_q.mem_read;
  assign ex_mem_2_reg = ctl_q.mem_2_reg;
  assign ex_mem_write = ctl_q.mem_write;
  assign ex_alu_src   = ctl_q.alu_src;
  assign ex_reg_write = ctl_q.reg_write;
  assign ex_jump      = ctl_q.jump;
  assign ex_rd        = rd_q;
  assign ex_valid     = valid_q;
  assign ex_src       = state_q;
  assign lu_cnt       = lu_cnt_q;
  assign fl_cnt       = fl_cnt_q;

endmodule

// File: tb/tb_decode_exec_reg.sv
// ---------------------------------------------------------------------------
// tb_decode_exec_reg
//
// Directed bench for decode_exec_reg. Every step drives one cycle of inputs,
// checks the combinational IF/ID controls, and pushes the expected EX-side
// state onto a scoreboard queue. After the clock edge that entry is popped
// and compared against the registered outputs.
// ---------------------------------------------------------------------------
module tb_decode_exec_reg;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [1:0]  ctl_alu_op;
  logic        ctl_reg_dst, ctl_branch, ctl_mem_read, ctl_mem_2_reg;
  logic        ctl_mem_write, ctl_alu_src, ctl_reg_write, ctl_jump;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        ex_redirect, ex_hold;
  logic [1:0]  ex_alu_op;
  logic        ex_reg_dst, ex_branch, ex_mem_read, ex_mem_2_reg;
  logic        ex_mem_write, ex_alu_src, ex_reg_write, ex_jump;
  logic [4:0]  ex_rd;
  logic        ex_valid;
  logic        stall_if_id, flush_if_id;
  logic [1:0]  ex_src;
  logic [15:0] lu_cnt, fl_cnt;

  // Control bundle bit order: {regDst, branch, memRead, mem2Reg, memWrite,
  // aluSrc, regWrite, jump}
  localparam logic [7:0] CtlRType = 8'b1000_0010;
  localparam logic [7:0] CtlLoad  = 8'b0011_0110;
  localparam logic [7:0] CtlStore = 8'b0000_1100;
  localparam logic [7:0] CtlAll   = 8'b1111_1111;

  typedef struct {
    string       tag;
    logic [9:0]  bundle;
    logic [4:0]  rd;
    logic        valid;
    logic [1:0]  src;
    logic [15:0] lu;
    logic [15:0] fl;
  } expRec_t;

  expRec_t scoreQ[$];

  int errorCount = 0;
  int checkCount = 0;

  // Reference model of the EX-side state, written from the behaviour rules.
  logic [9:0]  mBundle = '0;
  logic [4:0]  mRd     = '0;
  logic        mValid  = 1'b0;
  logic [1:0]  mSrc    = 2'b00;
  logic [15:0] mLu     = '0;
  logic [15:0] mFl     = '0;

  decode_exec_reg dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .ctl_alu_op   (ctl_alu_op),
    .ctl_reg_dst  (ctl_reg_dst),
    .ctl_branch   (ctl_branch),
    .ctl_mem_read (ctl_mem_read),
    .ctl_mem_2_reg(ctl_mem_2_reg),
    .ctl_mem_write(ctl_mem_write),
    .ctl_alu_src  (ctl_alu_src),
    .ctl_reg_write(ctl_reg_write),
    .ctl_jump     (ctl_jump),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rd        (id_rd),
    .ex_redirect  (ex_redirect),
    .ex_hold      (ex_hold),
    .ex_alu_op    (ex_alu_op),
    .ex_reg_dst   (ex_reg_dst),
    .ex_branch    (ex_branch),
    .ex_mem_read  (ex_mem_read),
    .ex_mem_2_reg (ex_mem_2_reg),
    .ex_mem_write (ex_mem_write),
    .ex_alu_src   (ex_alu_src),
    .ex_reg_write (ex_reg_write),
    .ex_jump      (ex_jump),
    .ex_rd        (ex_rd),
    .ex_valid     (ex_valid),
    .stall_if_id  (stall_if_id),
    .flush_if_id  (flush_if_id),
    .ex_src       (ex_src),
    .lu_cnt       (lu_cnt),
    .fl_cnt       (fl_cnt)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point used by every check in the bench.
  task automatic checkValue(input string tag, input logic [15:0] observed,
                            input logic [15:0] expected);
    checkCount++;
    assert (observed === expected)
    else begin
      errorCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic [15:0] satInc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Drive one cycle of inputs, check the IF/ID controls, advance the model
  // and push the expected post-edge EX state.
  task automatic applyStimulus(input string tag, input logic rstV, input logic holdV,
                               input logic redirV, input logic validV,
                               input logic [1:0] aluOp, input logic [7:0] ctl,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd);
    logic    loadUse;
    logic    expStall;
    logic    expFlush;
    expRec_t e;
    rst         = rstV;
    ex_hold     = holdV;
    ex_redirect = redirV;
    id_valid    = validV;
    ctl_alu_op  = aluOp;
    {ctl_reg_dst, ctl_branch, ctl_mem_read, ctl_mem_2_reg,
     ctl_mem_write, ctl_alu_src, ctl_reg_write, ctl_jump} = ctl;
    id_rs1      = rs1;
    id_rs2      = rs2;
    id_rd       = rd;

    loadUse  = validV && mValid && mBundle[5] && (mRd != 5'd0) && (mRd == rs1 || mRd == rs2);
    expStall = !rstV && (holdV || (!redirV && loadUse));
    expFlush = !rstV && !holdV && redirV;
    #1;
    checkValue({tag, ".stall"}, {15'd0, stall_if_id}, {15'd0, expStall});
    checkValue({tag, ".flush"}, {15'd0, flush_if_id}, {15'd0, expFlush});

    if (rstV) begin
      mBundle = '0; mRd = '0; mValid = 1'b0; mSrc = 2'b00; mLu = '0; mFl = '0;
    end else if (holdV) begin
      // frozen
    end else if (redirV) begin
      mBundle = '0; mRd = '0; mValid = 1'b0; mSrc = 2'b10; mFl = satInc(mFl);
    end else if (loadUse) begin
      mBundle = '0; mRd = '0; mValid = 1'b0; mSrc = 2'b01; mLu = satInc(mLu);
    end else begin
      mBundle = validV ? {aluOp, ctl} : 10'd0;
      mRd     = validV ? rd : 5'd0;
      mValid  = validV;
      mSrc    = 2'b00;
    end
    e.tag = tag; e.bundle = mBundle; e.rd = mRd; e.valid = mValid;
    e.src = mSrc; e.lu = mLu; e.fl = mFl;
    scoreQ.push_back(e);
  endtask

  // Pop the oldest expectation and compare it with the registered outputs.
  task automatic checkOutput();
    expRec_t e;
    logic [9:0] obsBundle;
    checkCount++;
    assert (scoreQ.size() > 0)
    else begin
      errorCount++;
      $error("[TB] FAIL scoreboard observed=empty expected=entry");
    end
    if (scoreQ.size() > 0) begin
      e = scoreQ.pop_front();
      obsBundle = {ex_alu_op, ex_reg_dst, ex_branch, ex_mem_read, ex_mem_2_reg,
                   ex_mem_write, ex_alu_src, ex_reg_write, ex_jump};
      checkValue({e.tag, ".bundle"}, {6'd0, obsBundle}, {6'd0, e.bundle});
      checkValue({e.tag, ".rd"},     {11'd0, ex_rd},    {11'd0, e.rd});
      checkValue({e.tag, ".valid"},  {15'd0, ex_valid}, {15'd0, e.valid});
      checkValue({e.tag, ".src"},    {14'd0, ex_src},   {14'd0, e.src});
      checkValue({e.tag, ".lu"},     lu_cnt,            e.lu);
      checkValue({e.tag, ".fl"},     fl_cnt,            e.fl);
    end
  endtask

  // One full cycle: drive at the falling edge, compare just after the rise.
  task automatic step(input string tag, input logic rstV, input logic holdV,
                      input logic redirV, input logic validV,
                      input logic [1:0] aluOp, input logic [7:0] ctl,
                      input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd);
    applyStimulus(tag, rstV, holdV, redirV, validV, aluOp, ctl, rs1, rs2, rd);
    @(posedge clk);
    #1;
    checkOutput();
    @(negedge clk);
  endtask

  initial begin
    int fillCount;
    rst = 1'b1; ex_hold = 1'b0; ex_redirect = 1'b0; id_valid = 1'b0;
    ctl_alu_op = 2'b00;
    {ctl_reg_dst, ctl_branch, ctl_mem_read, ctl_mem_2_reg,
     ctl_mem_write, ctl_alu_src, ctl_reg_write, ctl_jump} = 8'd0;
    id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    @(negedge clk);

    // Reset state
    step("reset", 1, 0, 0, 0, 2'b00, 8'd0, 0, 0, 0);
    checkValue("reset.src_const", {14'd0, ex_src}, 16'd0);

    // Normal R-type flow
    step("rtype", 0, 0, 0, 1, 2'b10, CtlRType, 1, 2, 5);
    checkValue("rtype.alu_op", {14'd0, ex_alu_op}, 16'd2);
    checkValue("rtype.reg_write", {15'd0, ex_reg_write}, 16'd1);
    checkValue("rtype.rd", {11'd0, ex_rd}, 16'd5);
    checkValue("rtype.valid", {15'd0, ex_valid}, 16'd1);

    // Invalid ID slot with all control inputs set enters as a bubble
    step("invalid", 0, 0, 0, 0, 2'b11, CtlAll, 3, 4, 6);
    checkValue("invalid.mem_write", {15'd0, ex_mem_write}, 16'd0);

    // Load-use on rs2: one stall, bubble, then the instruction enters EX
    step("load7", 0, 0, 0, 1, 2'b00, CtlLoad, 1, 0, 7);
    step("lu_stall", 0, 0, 0, 1, 2'b10, CtlRType, 3, 7, 9);
    checkValue("lu_stall.src", {14'd0, ex_src}, 16'd1);
    checkValue("lu_stall.lu_cnt", lu_cnt, 16'd1);
    step("lu_enter", 0, 0, 0, 1, 2'b10, CtlRType, 3, 7, 9);
    checkValue("lu_enter.rd", {11'd0, ex_rd}, 16'd9);

    // Load to x0 never stalls
    step("load0", 0, 0, 0, 1, 2'b00, CtlLoad, 2, 0, 0);
    step("x0_nostall", 0, 0, 0, 1, 2'b00, CtlStore, 0, 3, 0);
    checkValue("x0_nostall.lu_cnt", lu_cnt, 16'd1);

    // Redirect coinciding with load-use: flush wins
    step("load4", 0, 0, 0, 1, 2'b00, CtlLoad, 1, 0, 4);
    step("redir_lu", 0, 0, 1, 1, 2'b10, CtlRType, 4, 0, 10);
    checkValue("redir_lu.src", {14'd0, ex_src}, 16'd2);
    checkValue("redir_lu.fl_cnt", fl_cnt, 16'd1);
    checkValue("redir_lu.lu_cnt", lu_cnt, 16'd1);

    // Hold for 3 cycles with redirect and load-use both pending
    step("load6", 0, 0, 0, 1, 2'b00, CtlLoad, 1, 0, 6);
    for (int i = 0; i < 3; i++)
      step("hold", 0, 1, 1, 1, 2'b10, CtlRType, 6, 0, 11);
    checkValue("hold.rd", {11'd0, ex_rd}, 16'd6);
    checkValue("hold.mem_read", {15'd0, ex_mem_read}, 16'd1);
    checkValue("hold.fl_cnt", fl_cnt, 16'd1);
    step("hold_release", 0, 0, 0, 1, 2'b10, CtlRType, 6, 0, 11);
    step("after_lu", 0, 0, 0, 1, 2'b10, CtlRType, 6, 0, 11);

    // Back-to-back redirects
    step("redir_a", 0, 0, 1, 1, 2'b01, CtlRType, 1, 2, 12);
    step("redir_b", 0, 0, 1, 1, 2'b01, CtlRType, 1, 2, 13);
    checkValue("redir_b.fl_cnt", fl_cnt, 16'd3);

    // Run fl_cnt up to 16'hFFFE with a long burst of redirects
    fillCount = 32'h0000_FFFE - int'(mFl);
    rst = 1'b0; ex_hold = 1'b0; ex_redirect = 1'b1; id_valid = 1'b0;
    repeat (fillCount) @(posedge clk);
    @(negedge clk);
    mFl = 16'hFFFE; mBundle = '0; mRd = '0; mValid = 1'b0; mSrc = 2'b10;
    checkValue("fill.fl_cnt", fl_cnt, 16'hFFFE);
    for (int i = 0; i < 3; i++)
      step("sat", 0, 0, 1, 1, 2'b00, CtlRType, 1, 2, 3);
    checkValue("sat.fl_cnt", fl_cnt, 16'hFFFF);

    // Reset in the cycle a load-use stall would occur
    step("load8", 0, 0, 0, 1, 2'b00, CtlLoad, 1, 0, 8);
    step("rst_mid_stall", 1, 1, 1, 1, 2'b10, CtlRType, 8, 0, 14);
    checkValue("rst_mid_stall.fl_cnt", fl_cnt, 16'd0);

    // Reset during a BUB_LU cycle
    step("load8b", 0, 0, 0, 1, 2'b00, CtlLoad, 1, 0, 8);
    step("bub_lu", 0, 0, 0, 1, 2'b10, CtlRType, 8, 0, 15);
    checkValue("bub_lu.src", {14'd0, ex_src}, 16'd1);
    step("rst_bub_lu", 1, 1, 1, 1, 2'b10, CtlRType, 8, 0, 15);
    checkValue("rst_bub_lu.src", {14'd0, ex_src}, 16'd0);
    checkValue("rst_bub_lu.lu_cnt", lu_cnt, 16'd0);

    // First cycle after reset runs normally
    step("post_rst", 0, 0, 0, 1, 2'b10, CtlRType, 1, 2, 5);
    checkValue("post_rst.valid", {15'd0, ex_valid}, 16'd1);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
